// File: rtl/cache_arbiter.sv
// cache_arbiter
//   Shares the single cacheline-adapter port between the I-cache (line fills only)
//   and the D-cache (fills and writebacks). Only one transaction is in flight at a
//   time. When both sides ask in the same cycle, the grant alternates, so neither
//   side can be starved.
//
//   state  | meaning
//   IDLE   | no transaction in flight; arbitrate the pending requests
//   I_BUSY | I-cache fill in flight on the adapter port
//   D_BUSY | D-cache fill or writeback in flight on the adapter port
//
// Ports
//   clk, rst                       clock; synchronous active-high reset
//   i_pmem_*                       I-cache side: read request, address, rdata, resp
//   d_pmem_*                       D-cache side: read/write request, address, wdata,
//                                  rdata, resp
//   pmem_*                         adapter side: read/write, address, wdata (all
//                                  latched at grant), rdata, resp
module cache_arbiter #(
  parameter int unsigned LINE_WIDTH = 256,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_pmem_read,
  input  logic [ADDR_WIDTH-1:0] i_pmem_address,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  output logic                  i_pmem_resp,
  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [ADDR_WIDTH-1:0] d_pmem_address,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  d_pmem_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2
  } state_e;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  state_e                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
  logic                  op_write_q, op_write_d;

  logic i_req;
  logic d_req;
  logic grant_i;

  // State register. last_grant resets to D so the first contended grant goes to I.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_D;
      addr_q       <= '0;
      wdata_q      <= '0;
      op_write_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      op_write_q   <= op_write_d;
    end
  end

  assign i_req   = i_pmem_read;
  assign d_req   = d_pmem_read | d_pmem_write;
  // I wins when it is alone, or when both ask and D had the previous grant.
  assign grant_i = i_req & (~d_req | (last_grant_q == GRANT_D));

  // Next-state and grant-time latching.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    op_write_d   = op_write_q;
    case (state_q)
      IDLE: begin
        if (grant_i) begin
          state_d      = I_BUSY;
          last_grant_d = GRANT_I;
          addr_d       = i_pmem_address;
          op_write_d   = 1'b0;
        end else if (d_req) begin
          state_d      = D_BUSY;
          last_grant_d = GRANT_D;
          addr_d       = d_pmem_address;
          wdata_d      = d_pmem_wdata;
          // A simultaneous read+write is illegal; treat it as the writeback.
          op_write_d   = d_pmem_write;
        end
      end
      I_BUSY, D_BUSY: begin
        if (pmem_resp) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs. Requester inputs are never looked at while busy, so the adapter sees
  // stable latched values for the whole transaction.
  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    i_pmem_resp  = 1'b0;
    d_pmem_resp  = 1'b0;
    pmem_address = addr_q;
    pmem_wdata   = wdata_q;
    i_pmem_rdata = pmem_rdata;
    d_pmem_rdata = pmem_rdata;
    if (state_q == I_BUSY || state_q == D_BUSY) begin
      pmem_read  = ~op_write_q;
      pmem_write = op_write_q;
    end
    if (state_q == I_BUSY) i_pmem_resp = pmem_resp;
    if (state_q == D_BUSY) d_pmem_resp = pmem_resp;
  end

endmodule

// File: tb/tb_cache_arbiter.sv
module tb_cache_arbiter;
  localparam int unsigned LW = 256;
  localparam int unsigned AW = 32;

  logic          clk;
  logic          rst;
  logic          i_pmem_read;
  logic [AW-1:0] i_pmem_address;
  logic [LW-1:0] i_pmem_rdata;
  logic          i_pmem_resp;
  logic          d_pmem_read;
  logic          d_pmem_write;
  logic [AW-1:0] d_pmem_address;
  logic [LW-1:0] d_pmem_wdata;
  logic [LW-1:0] d_pmem_rdata;
  logic          d_pmem_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;

  int n_checks;
  int n_errors;

  cache_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_pmem_read    (i_pmem_read),
    .i_pmem_address (i_pmem_address),
    .i_pmem_rdata   (i_pmem_rdata),
    .i_pmem_resp    (i_pmem_resp),
    .d_pmem_read    (d_pmem_read),
    .d_pmem_write   (d_pmem_write),
    .d_pmem_address (d_pmem_address),
    .d_pmem_wdata   (d_pmem_wdata),
    .d_pmem_rdata   (d_pmem_rdata),
    .d_pmem_resp    (d_pmem_resp),
    .pmem_read      (pmem_read),
    .pmem_write     (pmem_write),
    .pmem_address   (pmem_address),
    .pmem_wdata     (pmem_wdata),
    .pmem_rdata     (pmem_rdata),
    .pmem_resp      (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Adapter stand-in: waits (bounded) for a request, records what the arbiter
  // presents, returns one response and records the requester-side result.
  // Enters and leaves one time unit after a rising edge.
  task automatic serve(input logic [LW-1:0] rd,
                       output logic rd_o, output logic wr_o,
                       output logic [AW-1:0] a_o, output logic [LW-1:0] wd_o,
                       output logic ir_o, output logic dr_o,
                       output logic [LW-1:0] rdat_o, output bit to);
    to = 1'b1;
    rd_o = 1'b0; wr_o = 1'b0; a_o = '0; wd_o = '0;
    ir_o = 1'b0; dr_o = 1'b0; rdat_o = '0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (pmem_read || pmem_write) begin
        to = 1'b0;
        break;
      end
    end
    if (!to) begin
      rd_o = pmem_read;
      wr_o = pmem_write;
      a_o  = pmem_address;
      wd_o = pmem_wdata;
      @(posedge clk); #1;
      pmem_resp  = 1'b1;
      pmem_rdata = rd;
      @(negedge clk);
      ir_o   = i_pmem_resp;
      dr_o   = d_pmem_resp;
      rdat_o = d_pmem_resp ? d_pmem_rdata : i_pmem_rdata;
    end
    @(posedge clk); #1;
    pmem_resp = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++;
      if ({pmem_read, pmem_write} !== 2'b00) begin
        n_errors++;
        $display("FAIL reset_req cyc%0d: got %b expected 00", c, {pmem_read, pmem_write});
      end
      n_checks++;
      if ({i_pmem_resp, d_pmem_resp} !== 2'b00) begin
        n_errors++;
        $display("FAIL reset_resp cyc%0d: got %b expected 00", c, {i_pmem_resp, d_pmem_resp});
      end
      n_checks++;
      if (pmem_address !== 32'h0) begin
        n_errors++;
        $display("FAIL reset_addr cyc%0d: got %h expected 0", c, pmem_address);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_lone_i();
    logic [LW-1:0] pat;
    pat = {8{32'hDEADBEEF}};
    i_pmem_read    = 1'b1;
    i_pmem_address = 32'h0000_1000;
    @(negedge clk);
    n_checks++;
    if (pmem_read !== 1'b0) begin
      n_errors++;
      $display("FAIL lone_i_latency: got pmem_read %b expected 0", pmem_read);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if ({pmem_read, pmem_write} !== 2'b10) begin
      n_errors++;
      $display("FAIL lone_i_req: got %b expected 10", {pmem_read, pmem_write});
    end
    n_checks++;
    if (pmem_address !== 32'h0000_1000) begin
      n_errors++;
      $display("FAIL lone_i_addr: got %h expected 00001000", pmem_address);
    end
    repeat (3) @(posedge clk);
    #1;
    pmem_resp  = 1'b1;
    pmem_rdata = pat;
    @(negedge clk);
    n_checks++;
    if ({i_pmem_resp, d_pmem_resp} !== 2'b10) begin
      n_errors++;
      $display("FAIL lone_i_resp: got %b expected 10", {i_pmem_resp, d_pmem_resp});
    end
    n_checks++;
    if (i_pmem_rdata !== pat) begin
      n_errors++;
      $display("FAIL lone_i_rdata: got %h expected %h", i_pmem_rdata, pat);
    end
    @(posedge clk); #1;
    pmem_resp   = 1'b0;
    i_pmem_read = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({pmem_read, i_pmem_resp} !== 2'b00) begin
      n_errors++;
      $display("FAIL lone_i_done: got %b expected 00", {pmem_read, i_pmem_resp});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_simultaneous();
    logic rd, wr, ir, dr;
    logic [AW-1:0] a;
    logic [LW-1:0] wd, rdat, a5;
    bit to;
    a5 = {32{8'hA5}};
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    i_pmem_read    = 1'b1;
    i_pmem_address = 32'h0000_2000;
    d_pmem_write   = 1'b1;
    d_pmem_address = 32'h0000_3000;
    d_pmem_wdata   = a5;
    serve({8{32'h1111_2222}}, rd, wr, a, wd, ir, dr, rdat, to);
    i_pmem_read = 1'b0;
    n_checks++;
    if (to) begin
      n_errors++;
      $display("FAIL sim_first_timeout: got no request expected I read");
    end
    n_checks++;
    if ({rd, wr, a, ir, dr} !== {2'b10, 32'h0000_2000, 2'b10}) begin
      n_errors++;
      $display("FAIL sim_first: got rw=%b%b addr=%h resp=%b%b expected rw=10 addr=00002000 resp=10",
               rd, wr, a, ir, dr);
    end
    @(negedge clk);
    n_checks++;
    if ({pmem_read, pmem_write} !== 2'b00) begin
      n_errors++;
      $display("FAIL sim_idle_gap: got %b expected 00", {pmem_read, pmem_write});
    end
    @(posedge clk); #1;
    serve({8{32'h3333_4444}}, rd, wr, a, wd, ir, dr, rdat, to);
    d_pmem_write = 1'b0;
    n_checks++;
    if ({to, rd, wr, a, ir, dr} !== {1'b0, 2'b01, 32'h0000_3000, 2'b01}) begin
      n_errors++;
      $display("FAIL sim_second: got to=%b rw=%b%b addr=%h resp=%b%b expected to=0 rw=01 addr=00003000 resp=01",
               to, rd, wr, a, ir, dr);
    end
    n_checks++;
    if (wd !== a5) begin
      n_errors++;
      $display("FAIL sim_wdata: got %h expected %h", wd, a5);
    end
  endtask

  task automatic test_alternation();
    logic rd, wr, ir, dr;
    logic [AW-1:0] a;
    logic [LW-1:0] wd, rdat, pat;
    bit to;
    // Previous grant was D, so the sequence starts with I.
    i_pmem_read    = 1'b1;
    i_pmem_address = 32'h0000_6000;
    d_pmem_read    = 1'b1;
    d_pmem_address = 32'h0000_7000;
    for (int n = 0; n < 4; n++) begin
      pat = {8{n[31:0] + 32'hC0DE_0000}};
      serve(pat, rd, wr, a, wd, ir, dr, rdat, to);
      n_checks++;
      if (to) begin
        n_errors++;
        $display("FAIL alt_timeout txn%0d: got no request expected one", n);
      end
      n_checks++;
      if ((n % 2) == 0) begin
        if ({rd, a, ir, dr} !== {1'b1, 32'h0000_6000, 2'b10}) begin
          n_errors++;
          $display("FAIL alt_grant txn%0d: got rd=%b addr=%h resp=%b%b expected rd=1 addr=00006000 resp=10",
                   n, rd, a, ir, dr);
        end
      end else begin
        if ({rd, a, ir, dr} !== {1'b1, 32'h0000_7000, 2'b01}) begin
          n_errors++;
          $display("FAIL alt_grant txn%0d: got rd=%b addr=%h resp=%b%b expected rd=1 addr=00007000 resp=01",
                   n, rd, a, ir, dr);
        end
      end
      n_checks++;
      if (rdat !== pat) begin
        n_errors++;
        $display("FAIL alt_rdata txn%0d: got %h expected %h", n, rdat, pat);
      end
    end
    i_pmem_read = 1'b0;
    d_pmem_read = 1'b0;
  endtask

  task automatic test_mid_change();
    d_pmem_read    = 1'b1;
    d_pmem_address = 32'h0000_4000;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if ({pmem_read, pmem_address} !== {1'b1, 32'h0000_4000}) begin
      n_errors++;
      $display("FAIL mid_grant: got rd=%b addr=%h expected rd=1 addr=00004000", pmem_read, pmem_address);
    end
    d_pmem_address = 32'h0000_5000;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_checks++;
      if (pmem_address !== 32'h0000_4000) begin
        n_errors++;
        $display("FAIL mid_hold cyc%0d: got %h expected 00004000", c, pmem_address);
      end
    end
    @(posedge clk); #1;
    pmem_resp = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({d_pmem_resp, i_pmem_resp, pmem_address} !== {2'b10, 32'h0000_4000}) begin
      n_errors++;
      $display("FAIL mid_resp: got d=%b i=%b addr=%h expected d=1 i=0 addr=00004000",
               d_pmem_resp, i_pmem_resp, pmem_address);
    end
    @(posedge clk); #1;
    pmem_resp   = 1'b0;
    d_pmem_read = 1'b0;
  endtask

  task automatic test_rw_violation();
    logic rd, wr, ir, dr;
    logic [AW-1:0] a;
    logic [LW-1:0] wd, rdat, pat;
    bit to;
    pat = {32{8'h5A}};
    d_pmem_read    = 1'b1;
    d_pmem_write   = 1'b1;
    d_pmem_address = 32'h0000_9000;
    d_pmem_wdata   = pat;
    serve('0, rd, wr, a, wd, ir, dr, rdat, to);
    d_pmem_read  = 1'b0;
    d_pmem_write = 1'b0;
    n_checks++;
    if ({to, rd, wr, a, dr} !== {1'b0, 2'b01, 32'h0000_9000, 1'b1}) begin
      n_errors++;
      $display("FAIL rw_both: got to=%b rw=%b%b addr=%h dresp=%b expected to=0 rw=01 addr=00009000 dresp=1",
               to, rd, wr, a, dr);
    end
    n_checks++;
    if (wd !== pat) begin
      n_errors++;
      $display("FAIL rw_wdata: got %h expected %h", wd, pat);
    end
  endtask

  task automatic test_stray_and_reset();
    pmem_resp = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({i_pmem_resp, d_pmem_resp} !== 2'b00) begin
      n_errors++;
      $display("FAIL stray_resp: got %b expected 00", {i_pmem_resp, d_pmem_resp});
    end
    @(posedge clk); #1;
    pmem_resp = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({pmem_read, pmem_write} !== 2'b00) begin
      n_errors++;
      $display("FAIL stray_state: got %b expected 00", {pmem_read, pmem_write});
    end
    @(posedge clk); #1;
    i_pmem_read    = 1'b1;
    i_pmem_address = 32'h0000_8000;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if ({pmem_read, pmem_address} !== {1'b1, 32'h0000_8000}) begin
      n_errors++;
      $display("FAIL rst_pre: got rd=%b addr=%h expected rd=1 addr=00008000", pmem_read, pmem_address);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if ({pmem_read, pmem_write, i_pmem_resp, pmem_address} !== {3'b000, 32'h0}) begin
      n_errors++;
      $display("FAIL rst_abort: got rw=%b%b iresp=%b addr=%h expected rw=00 iresp=0 addr=00000000",
               pmem_read, pmem_write, i_pmem_resp, pmem_address);
    end
    @(posedge clk); #1;
    rst         = 1'b0;
    i_pmem_read = 1'b0;
  endtask

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    rst            = 1'b1;
    i_pmem_read    = 1'b0;
    i_pmem_address = '0;
    d_pmem_read    = 1'b0;
    d_pmem_write   = 1'b0;
    d_pmem_address = '0;
    d_pmem_wdata   = '0;
    pmem_rdata     = '0;
    pmem_resp      = 1'b0;
    test_reset();
    test_lone_i();
    test_simultaneous();
    test_alternation();
    test_mid_change();
    test_rw_violation();
    test_stray_and_reset();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
